gal_sop_seq_eval: RTL and testbench

// - Multi-channel sum-of-products evaluator. Each channel's SOP can have more product terms than one PLA pass allows.
// - Terms are processed over several cycles, PLA_CHUNK terms per cycle, and ORed into a per-channel accumulator.
// - Does the same work as splitting an oversized $sop across GAL_SOP cells, but spreads it over time instead of area.
// - Sits between a registered input stage and the output macrocells; uses a valid/ready handshake on both sides.

---
 rtl/gal_pla_pkg.sv | 22 ++
 rtl/gal_sop_chunk.sv | 48 ++++
 rtl/gal_sop_seq_eval.sv | 139 +++++++++++++
 tb/tb_gal_sop_seq_eval.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gal_pla_pkg.sv
// Shared definitions for the sequential sum-of-products evaluator.
//   LIT_*     : 2-bit literal codes stored per variable per product term.
//   state_t   : controller states of gal_sop_seq_eval.
//   ceil_div  : integer ceiling division, used to size the chunk counter.
package gal_pla_pkg;

  localparam logic [1:0] LIT_UNUSED = 2'b00;  // variable does not appear in the term
  localparam logic [1:0] LIT_INV    = 2'b01;  // variable appears inverted
  localparam logic [1:0] LIT_TRUE   = 2'b10;  // variable appears true
  localparam logic [1:0] LIT_CONTRA = 2'b11;  // term can never be true

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/gal_sop_chunk.sv
// One channel's PLA slice: ORs together the PLA_CHUNK product terms selected
// by the chunk counter, evaluated on the latched input vector. Purely
// combinational.
//   in_q_i  [WIDTH]            latched input variables
//   cnt_i   [CNT_W]            chunk index k; selects terms k*PLA_CHUNK ..
//   tbl_i   [DEPTH*2*WIDTH]    this channel's term table
//   hit_o                      OR of the selected terms
module gal_sop_chunk
  import gal_pla_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int PLA_CHUNK = 8,
  parameter int CNT_W     = 1
) (
  input  logic [WIDTH-1:0]         in_q_i,
  input  logic [CNT_W-1:0]         cnt_i,
  input  logic [DEPTH*2*WIDTH-1:0] tbl_i,
  output logic                     hit_o
);

  function automatic logic lit_match(input logic [1:0] lit, input logic x);
    case (lit)
      LIT_UNUSED: return 1'b1;
      LIT_INV:    return ~x;
      LIT_TRUE:   return x;
      LIT_CONTRA: return 1'b0;
      default:    return 1'b0;
    endcase
  endfunction

  logic [DEPTH-1:0] term_true;
  logic [DEPTH-1:0] term_sel;

  // Only real terms exist here, so the padding slots of the last chunk
  // contribute nothing: a chunk selects just the terms whose index maps to it.
  for (genvar t = 0; t < DEPTH; t++) begin : g_term
    logic [WIDTH-1:0] lit_ok;
    for (genvar v = 0; v < WIDTH; v++) begin : g_var
      assign lit_ok[v] = lit_match(tbl_i[2*WIDTH*t + 2*v +: 2], in_q_i[v]);
    end
    assign term_true[t] = &lit_ok;
    assign term_sel[t]  = (cnt_i == CNT_W'(t / PLA_CHUNK));
  end

  assign hit_o = |(term_true & term_sel);

endmodule

// File: rtl/gal_sop_seq_eval.sv
// Multi-channel sum-of-products evaluator that walks each channel's product
// terms PLA_CHUNK at a time and ORs the partial results into an accumulator.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready only in IDLE
//   in_data   [WIDTH]     input variable vector, latched on accept
//   out_valid / out_ready output handshake; result held until taken
//   out_data  [NUM_OUT]   per-channel SOP result (kept after the handshake)
//   busy                  high while evaluating
// Build option: define GAL_SOP_EARLY_EXIT_EN to leave EVAL as soon as every
// channel is already 1; out_data is the same, only latency shrinks.
module gal_sop_seq_eval
  import gal_pla_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int NUM_OUT   = 2,
  parameter int PLA_CHUNK = 8,
  parameter logic [NUM_OUT*DEPTH*2*WIDTH-1:0] TABLE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_data,
  output logic               busy
);

  localparam int TBL_BITS = NUM_OUT * DEPTH * 2 * WIDTH;
  localparam int CH_BITS  = DEPTH * 2 * WIDTH;
  localparam int NCHUNK   = ceil_div(DEPTH, PLA_CHUNK);
  localparam int CNT_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  if (WIDTH < 1 || DEPTH < 1 || NUM_OUT < 1 || PLA_CHUNK < 1) begin : g_bad_param
    $fatal(1, "gal_sop_seq_eval: WIDTH, DEPTH, NUM_OUT and PLA_CHUNK must be >= 1");
  end
  if ($bits(TABLE) != TBL_BITS) begin : g_bad_table
    $fatal(1, "gal_sop_seq_eval: TABLE must be NUM_OUT*DEPTH*2*WIDTH bits");
  end

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_OUT-1:0]   acc_q, acc_d;
  logic [NUM_OUT-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, in_ready_q, busy_q;
  logic [WIDTH-1:0]     in_q;
  logic                 load_in;
  logic [NUM_OUT-1:0]   hit;
  logic                 early;

  for (genvar c = 0; c < NUM_OUT; c++) begin : g_ch
    gal_sop_chunk #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .PLA_CHUNK (PLA_CHUNK),
      .CNT_W     (CNT_W)
    ) u_chunk (
      .in_q_i (in_q),
      .cnt_i  (cnt_q),
      .tbl_i  (TABLE[c*CH_BITS +: CH_BITS]),
      .hit_o  (hit[c])
    );
  end

`ifdef GAL_SOP_EARLY_EXIT_EN
  // Once every channel is 1 the remaining chunks cannot change the result.
  assign early = &(acc_q | hit);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    load_in    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          load_in = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        acc_d = acc_q | hit;
        if (cnt_q == LAST_CNT || early) begin
          cnt_d      = '0;
          out_data_d = acc_d;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state so they
  // change on the same edge as the state, and are all low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d == EVAL);
    end
  end

  // Input latch: data only, captured on accept and ignored afterwards.
  always_ff @(posedge clk) begin
    if (load_in) in_q <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gal_sop_seq_eval.sv
// Directed bench for gal_sop_seq_eval: four instances with different term
// depths share clock, reset, in_data and out_ready; each has its own
// in_valid and outputs. Honours GAL_SOP_EARLY_EXIT_EN for expected latency.
module tb_gal_sop_seq_eval;

  // u0: DEPTH=4,  ch0 = a&~b (term 0), ch1 = d (term 0), rest contradiction
  localparam logic [63:0]  TAB0 = 64'hFFFFFF80_FFFFFF06;
  // u1: DEPTH=20, ch0 = c in term 8, ch1 = d in term 19
  localparam logic [319:0] TAB1 = {8'h80, {19{8'hFF}}, {11{8'hFF}}, 8'h20, {8{8'hFF}}};
  // u2: DEPTH=9,  ch0 all contradiction, ch1 term 8 constant true
  localparam logic [143:0] TAB2 = {8'h00, {17{8'hFF}}};
  // u3: DEPTH=24, ch0 term 0 constant true, ch1 = a (term 0) | b (term 23)
  localparam logic [383:0] TAB3 = {8'h08, {22{8'hFF}}, 8'h02, {23{8'hFF}}, 8'h00};

`ifdef GAL_SOP_EARLY_EXIT_EN
  localparam int EE_LAT = 2;
`else
  localparam int EE_LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       out_ready;
  logic       iv  [4];
  logic       rdy [4];
  logic       ov  [4];
  logic       bsy [4];
  logic [1:0] od  [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gal_sop_seq_eval #(.WIDTH(4), .DEPTH(4), .NUM_OUT(2), .PLA_CHUNK(8), .TABLE(TAB0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bsy[0]));
  gal_sop_seq_eval #(.WIDTH(4), .DEPTH(20), .NUM_OUT(2), .PLA_CHUNK(8), .TABLE(TAB1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bsy[1]));
  gal_sop_seq_eval #(.WIDTH(4), .DEPTH(9), .NUM_OUT(2), .PLA_CHUNK(8), .TABLE(TAB2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bsy[2]));
  gal_sop_seq_eval #(.WIDTH(4), .DEPTH(24), .NUM_OUT(2), .PLA_CHUNK(8), .TABLE(TAB3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rdy[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .busy(bsy[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for in_ready, present d for one accept edge, then scramble in_data.
  task automatic accept(input int id, input logic [3:0] d, input string tag);
    int n;
    n = 0;
    while (!rdy[id] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_in_ready"}, 32'(rdy[id]), 1);
    in_data = d;
    iv[id]  = 1'b1;
    @(posedge clk); #1;
    iv[id]  = 1'b0;
    in_data = ~d;
    check({tag, "_busy"}, 32'(bsy[id]), 1);
  endtask

  // Count edges from the accept edge until out_valid, then check the result.
  task automatic wait_out(input int id, input logic [1:0] exp, input int lat, input string tag);
    int n;
    n = 1;
    while (!ov[id] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_data"}, 32'(od[id]), 32'(exp));
    check({tag, "_busy_done"}, 32'(bsy[id]), 0);
  endtask

  task automatic take(input int id, input logic [1:0] exp, input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(ov[id]), 0);
    check({tag, "_ready_back"}, 32'(rdy[id]), 1);
    check({tag, "_data_kept"}, 32'(od[id]), 32'(exp));
  endtask

  task automatic run(input int id, input logic [3:0] d, input logic [1:0] exp,
                     input int lat, input string tag);
    accept(id, d, tag);
    wait_out(id, exp, lat, tag);
    take(id, exp, tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) iv[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_in_ready_%0d", i), 32'(rdy[i]), 0);
      check($sformatf("rst_out_valid_%0d", i), 32'(ov[i]), 0);
      check($sformatf("rst_busy_%0d", i), 32'(bsy[i]), 0);
      check($sformatf("rst_out_data_%0d", i), 32'(od[i]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(rdy[0]), 1);

    // Single pass (NCHUNK = 1)
    run(0, 4'b0001, 2'b01, 2, "u0_0001");
    run(0, 4'b0011, 2'b00, 2, "u0_0011");
    run(0, 4'b1000, 2'b10, 2, "u0_1000");

    // Backpressure: hold out_ready low for 5 cycles in DONE
    accept(0, 4'b1001, "bp");
    wait_out(0, 2'b11, 2, "bp");
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(i);
      check($sformatf("bp_hold_valid_%0d", i), 32'(ov[0]), 1);
      check($sformatf("bp_hold_data_%0d", i), 32'(od[0]), 32'(2'b11));
      check($sformatf("bp_hold_ready_%0d", i), 32'(rdy[0]), 0);
      @(posedge clk); #1;
    end
    take(0, 2'b11, "bp");

    // Multi-chunk (NCHUNK = 3)
    run(1, 4'b1000, 2'b10, 4, "u1_1000");
    run(1, 4'b0100, 2'b01, 4, "u1_0100");
    run(1, 4'b1100, 2'b11, 4, "u1_1100");
    run(1, 4'b0000, 2'b00, 4, "u1_0000");

    // Padding: last chunk holds one real term and seven padding slots
    run(2, 4'b0000, 2'b10, 3, "u2_0000");
    run(2, 4'b1111, 2'b10, 3, "u2_1111");

    // Early exit candidate and a term in the final chunk
    run(3, 4'b0001, 2'b11, EE_LAT, "u3_ee");
    run(3, 4'b0010, 2'b11, 4, "u3_last");

    // Reset during EVAL cycle 1
    accept(3, 4'b0010, "mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bsy[3]), 0);
    check("mid_rst_in_ready", 32'(rdy[3]), 0);
    check("mid_rst_out_valid", 32'(ov[3]), 0);
    check("mid_rst_out_data", 32'(od[3]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(3, 4'b0000, 2'b01, 4, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
